mvm_seq_ctrl: RTL and testbench
===============================

// Module: mvm_seq_ctrl
// PURPOSE
//  Sequenced binary-vector x coefficient-matrix engine with a writable NxN coefficient file.
//  Accepts an N-bit 0/1 vector over a valid/ready handshake and accumulates one matrix row per cycle.
//  Then streams the N column sums out one per cycle over a valid/ready handshake.
//  Sits between the pin-level input shim and the output mux; replaces the flat combinational multiply.
// PARAMETERS
//  N       8               vector length and matrix dimension (rows = cols = N; power of 2, >=2)
//  DATA_W  8               coefficient width (unsigned)
//  ACC_W   DATA_W+$clog2(N) column-sum width; N*(2^DATA_W-1) always fits, so no overflow
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       asynchronous, active-high reset
//  wr_en     in   1       coefficient write strobe
//  wr_row    in   log2N   coefficient row index
//  wr_col    in   log2N   coefficient column index
//  wr_data   in   DATA_W  coefficient value
//  wr_err    out  1       1-cycle pulse: write attempted while not IDLE (write dropped)
//  in_valid  in   1       vector present
//  in_ready  out  1       engine can accept a vector (== state IDLE)
//  in_vec    in   N       vector; bit r selects row r
//  out_valid out  1       out_data/out_col valid
//  out_ready in   1       consumer accepts current column
//  out_data  out  ACC_W   column sum
//  out_col   out  log2N   column index of out_data
//  out_last  out  1       out_col == N-1 while out_valid
//  busy      out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; acc[*]=0; vec reg=0; row/col counters=0;
//   coef[r][c] = (r*N+c+1) mod 2^DATA_W; out_valid=0, out_data=0, out_col=0, out_last=0,
//   wr_err=0, busy=0, in_ready=1 once rst deasserts. Reset mid-ACC/OUT aborts; no partial output.
//  FSM: IDLE -> ACC on in_valid&in_ready (latch in_vec, clear acc, row=0).
//   ACC: each edge, for all c: acc[c] += vec[row] ? coef[row][c] : 0; row++.
//   ACC -> OUT on the edge processing row N-1 (exactly N ACC cycles).
//   OUT: out_valid=1, out_data=acc[col], out_col=col; on out_valid&out_ready: col++;
//   OUT -> IDLE on the handshake with col==N-1 (col returns to 0).
//  Latency: accept edge T0; out_valid first high after edge T0+N; N-column drain >= N cycles.
//  Backpressure: out_ready low holds out_data/out_col/out_last stable; no column skipped or repeated.
//  in_ready=0 in ACC/OUT; in_valid ignored there (producer must hold).
//  Back-to-back: the cycle after the last column handshake is IDLE with in_ready=1.
//  Writes: honoured only in IDLE, coef[wr_row][wr_col]<=wr_data at the edge.
//   Write + accept in the same IDLE cycle: write commits first; that vector uses the new value.
//   Write in ACC/OUT: dropped, wr_err=1 for exactly the next cycle (1 per offending cycle).
//  Arithmetic: unsigned, zero-extended to ACC_W; vector 0 yields all-zero sums.
//  No combinational path in_valid->in_ready or out_ready->out_valid (ready/valid are state-derived).
// TESTING
//  T1 reset defaults, in_vec=0xFF, out_ready=1 -> out_col 0..7 give 232+8c (0x0E8..0x120); out_last at col 7.
//  T2 in_vec=0x01 -> sums 1..8; in_vec=0x00 -> eight zeros; out_valid exactly N cycles after accept.
//  T3 write coef[3][5]=0xFF in IDLE, in_vec=0x08 -> col5=255, other cols 25+c.
//  T4 out_ready low 5 cycles at col 2 -> out_data=acc[2], out_col=2 stable; all 8 columns delivered once.
//  T5 write during ACC -> wr_err pulses 1 cycle, coef unchanged (rerun T1 values match).
//  T6 assert rst at 3rd ACC cycle -> out_valid=0, busy=0, coef defaults; next vector 0xFF reproduces T1.

Source files
------------

// File: rtl/mvm_seq_ctrl.sv
// Sequenced 0/1-vector x NxN coefficient-matrix engine: one row accumulated per cycle,
// then the N column sums streamed out over valid/ready.
module mvm_seq_ctrl #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = DATA_W + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [$clog2(N)-1:0] wr_row,
    input  logic [$clog2(N)-1:0] wr_col,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last,
    output logic                 busy
);
    localparam int LGN = $clog2(N);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t            state, state_nx;
    logic [N-1:0]      vec;
    logic [LGN-1:0]    row;
    logic [LGN-1:0]    col;
    logic [ACC_W-1:0]  acc  [N];
    logic [DATA_W-1:0] coef [N][N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ready/valid depend on state only, never on the partner's handshake input
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_col   = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = ACC;
            end
            ACC: begin
                if (row == LGN'(N - 1)) state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = acc[col];
                out_col   = col;
                out_last  = (col == LGN'(N - 1));
                if (out_ready && col == LGN'(N - 1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec    <= '0;
            row    <= '0;
            col    <= '0;
            wr_err <= 1'b0;
            for (int unsigned c = 0; c < N; c++) acc[c] <= '0;
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned c = 0; c < N; c++)
                    coef[r][c] <= DATA_W'(r * N + c + 1);
        end else begin
            wr_err <= wr_en && (state != IDLE);
            // a write in the accept cycle lands before the first ACC read of coef
            if (wr_en && state == IDLE) coef[wr_row][wr_col] <= wr_data;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec <= in_vec;
                        row <= '0;
                        col <= '0;
                        for (int unsigned c = 0; c < N; c++) acc[c] <= '0;
                    end
                end
                ACC: begin
                    for (int unsigned c = 0; c < N; c++)
                        if (vec[row]) acc[c] <= acc[c] + ACC_W'(coef[row][c]);
                    row <= row + 1'b1;
                end
                OUT: begin
                    if (out_ready) col <= col + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Scoreboard bench for mvm_seq_ctrl: expected column sums queued at vector accept,
// popped and compared at each output handshake.
module tb_mvm_seq_ctrl;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [2:0]  wr_col = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_data;
    logic [2:0]  out_col;
    logic        out_last;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int unsigned mcoef [N][N];
    int unsigned exp_q [$];

    always #5 clk = ~clk;

    mvm_seq_ctrl #(.N(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_err(wr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_col(out_col), .out_last(out_last), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mcoef[r][c] = (r * N + c + 1) % 256;
    endtask

    task automatic model_write(input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_row  = 3'(r);
        wr_col  = 3'(c);
        wr_data = 8'(d);
        mcoef[r][c] = d;
    endtask

    // drive one vector (optionally with a same-cycle coefficient write) and queue its sums
    task automatic send(input logic [7:0] v, input bit do_wr, input int r, input int c, input int d);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_vec   = v;
        if (do_wr) model_write(r, c, d);
        for (int cc = 0; cc < N; cc++) begin
            int unsigned s = 0;
            for (int rr = 0; rr < N; rr++) if (v[rr]) s += mcoef[rr][cc];
            exp_q.push_back(s);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wr_en    = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", in_ready, 0);
    endtask

    // collect N columns; optional stall at one column and optional write during ACC
    task automatic drain(input int stall_col, input int stall_n, input int wr_at);
        int cyc = 0, got = 0, stall = stall_n;
        bit seen = 0;
        out_ready = 1'b1;
        while (got < N && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (wr_at > 0 && cyc == wr_at + 1) begin
                wr_en = 1'b0;
                chk("wr_err_pulse", wr_err, 1);
            end
            if (wr_at > 0 && cyc == wr_at + 2) chk("wr_err_clear", wr_err, 0);
            if (wr_at > 0 && cyc == wr_at) begin
                wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'h55;
            end
            if (out_valid) begin
                if (!seen) begin
                    chk("latency", cyc, N);
                    seen = 1;
                end
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 0, 1);
                    got = N;
                end else if (stall > 0 && out_col == 3'(stall_col)) begin
                    out_ready = 1'b0;
                    stall--;
                    chk("stall_col", out_col, stall_col);
                    chk("stall_data", out_data, exp_q[0]);
                end else begin
                    out_ready = 1'b1;
                    chk("col", out_col, got);
                    chk("data", out_data, exp_q.pop_front());
                    chk("last", out_last, (got == N - 1));
                    got++;
                end
            end
        end
        if (got < N) chk("drain_timeout", got, N);
        @(posedge clk); #1;
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_busy", busy, 0);
        chk("b2b_out_valid", out_valid, 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_busy", busy, 0);
        #20;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // defaults, all rows: 232+8c
        send(8'hFF, 0, 0, 0, 0);
        drain(-1, 0, 0);
        send(8'h01, 0, 0, 0, 0);
        drain(-1, 0, 0);
        send(8'h00, 0, 0, 0, 0);
        drain(-1, 0, 0);

        // write during ACC is dropped; model untouched so all-rows sums unchanged
        send(8'hFF, 0, 0, 0, 0);
        drain(-1, 0, 2);
        send(8'hFF, 0, 0, 0, 0);
        drain(-1, 0, 0);

        // write alone in IDLE, then a write together with the accept
        model_write(3, 5, 8'hFF);
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("idle_wr_no_err", wr_err, 0);
        send(8'h08, 0, 0, 0, 0);
        drain(-1, 0, 0);
        send(8'h40, 1, 6, 0, 8'h10);
        drain(-1, 0, 0);

        // backpressure at column 2
        send(8'hA5, 0, 0, 0, 0);
        drain(2, 5, 0);

        // reset in the third ACC cycle aborts and restores coefficient defaults
        send(8'hFF, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        model_reset();
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_no_output", out_valid, 0);
        send(8'hFF, 0, 0, 0, 0);
        drain(-1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
